// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window sequencer.
// FLOAT_ONE/FLOAT_THREE are convenience constants for test stimulus.
package conv_pkg;

  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] FLOAT_ONE   = 32'h3F80_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_THREE = 32'h4040_0000;

  localparam int ADDR_W_DEF = 16;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap counters with registered pixel, weight and output addresses.
// Addresses are computed from the next counter values so they line up with the counters.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              tap_adv,
  input  logic              win_adv,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last_tap,
  output logic              last_win
);

  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;

  typedef logic [ADDR_W-1:0] a_t;
  localparam a_t ONE_A  = a_t'(1);
  localparam a_t IMGW_A = a_t'(IMG_W);
  localparam a_t K_A    = a_t'(K);
  localparam a_t OW_A   = a_t'(OW);
  localparam a_t KM1_A  = a_t'(K - 1);
  localparam a_t OWM1_A = a_t'(OW - 1);
  localparam a_t OHM1_A = a_t'(OH - 1);

  a_t r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  a_t pix_q, pix_d, wgt_q, wgt_d, oa_q, oa_d;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (restart) begin
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else begin
      // Tap and window counters both wrap to zero so the next window starts at tap 0.
      if (tap_adv) begin
        if (j_q == KM1_A) begin
          j_d = '0;
          i_d = (i_q == KM1_A) ? '0 : i_q + ONE_A;
        end else begin
          j_d = j_q + ONE_A;
        end
      end
      if (win_adv) begin
        if (c_q == OWM1_A) begin
          c_d = '0;
          r_d = (r_q == OHM1_A) ? '0 : r_q + ONE_A;
        end else begin
          c_d = c_q + ONE_A;
        end
      end
    end
    pix_d = (r_d + i_d) * IMGW_A + (c_d + j_d);
    wgt_d = i_d * K_A + j_d;
    oa_d  = r_d * OW_A + c_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      c_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      pix_q <= '0;
      wgt_q <= '0;
      oa_q  <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      i_q   <= i_d;
      j_q   <= j_d;
      pix_q <= pix_d;
      wgt_q <= wgt_d;
      oa_q  <= oa_d;
    end
  end

  assign pix_addr = pix_q;
  assign wgt_addr = wgt_q;
  assign out_addr = oa_q;
  assign last_tap = (i_q == KM1_A) && (j_q == KM1_A);
  assign last_win = (r_q == OHM1_A) && (c_q == OWM1_A);

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences a BasicConv MAC over every KxK window of an image and writes each result
// to the output memory through a ready/valid port.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int MAC_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] pix_rdata,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic [DATA_W-1:0] conv_a,
  output logic [DATA_W-1:0] conv_b,
  output logic              conv_start,
  output logic              conv_clr,
  input  logic [DATA_W-1:0] conv_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int DW = (MAC_LAT + 1 > 2) ? $clog2(MAC_LAT + 1) : 1;
  typedef logic [DW-1:0] drain_t;
  localparam drain_t DRAIN_LOAD = drain_t'(MAC_LAT);
  localparam drain_t DRAIN_ONE  = drain_t'(1);

  state_e              state_q, state_d;
  drain_t              drain_q, drain_d;
  logic [DATA_W-1:0]   conv_a_q, conv_a_d, conv_b_q, conv_b_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d, done_q, done_d, mem_rd_q, mem_rd_d;
  logic                conv_start_q, conv_start_d, conv_clr_q, conv_clr_d;
  logic                out_valid_q, out_valid_d;
  logic                restart, tap_adv, win_adv, last_tap, last_win;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tap_adv (tap_adv),
    .win_adv (win_adv),
    .pix_addr(pix_addr),
    .wgt_addr(wgt_addr),
    .out_addr(out_addr),
    .last_tap(last_tap),
    .last_win(last_win)
  );

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    conv_a_d   = conv_a_q;
    conv_b_d   = conv_b_q;
    out_data_d = out_data_q;
    restart    = 1'b0;
    tap_adv    = 1'b0;
    win_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          restart = 1'b1;
          state_d = ST_CLR;
        end
      end
      ST_CLR:   state_d = ST_FETCH;
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        conv_a_d = pix_rdata;
        conv_b_d = wgt_rdata;
        tap_adv  = 1'b1;
        if (last_tap) begin
          drain_d = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      // First DRAIN cycle coincides with the final conv_start pulse.
      ST_DRAIN: begin
        if (drain_q == '0) begin
          out_data_d = conv_c;
          state_d    = ST_WRITE;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      ST_WRITE: begin
        if (out_ready) begin
          win_adv = 1'b1;
          state_d = last_win ? ST_DONE : ST_CLR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    conv_clr_d   = (state_d == ST_CLR);
    mem_rd_d     = (state_d == ST_FETCH);
    out_valid_d  = (state_d == ST_WRITE);
    conv_start_d = (state_q == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      drain_q      <= '0;
      conv_a_q     <= '0;
      conv_b_q     <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      conv_start_q <= 1'b0;
      conv_clr_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      conv_a_q     <= conv_a_d;
      conv_b_q     <= conv_b_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_rd_q     <= mem_rd_d;
      conv_start_q <= conv_start_d;
      conv_clr_q   <= conv_clr_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd     = mem_rd_q;
  assign conv_a     = conv_a_q;
  assign conv_b     = conv_b_q;
  assign conv_start = conv_start_q;
  assign conv_clr   = conv_clr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on a 4x4 image with a 3x3 kernel,
// with a behavioural BasicConv (integer-valued floats) and synchronous-read memories.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int IMG_W = 4, IMG_H = 4, K = 3, MAC_LAT = 4, ADDR_W = 16, DATA_W = 32;
  localparam int NTAP = K * K, NWIN = 4, OW = IMG_W - K + 1;
  localparam int WIN_CYC = 1 + 2 * NTAP + (MAC_LAT + 1) + 1;

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, out_ready = 1'b1;
  logic busy, done, mem_rd, conv_start, conv_clr, out_valid;
  logic [ADDR_W-1:0] pix_addr, wgt_addr, out_addr;
  logic [DATA_W-1:0] pix_rdata = '0, wgt_rdata = '0, conv_a, conv_b, conv_c, out_data;

  always #5 clk = ~clk;

  conv_window_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .MAC_LAT(MAC_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .pix_addr(pix_addr), .wgt_addr(wgt_addr), .mem_rd(mem_rd),
    .pix_rdata(pix_rdata), .wgt_rdata(wgt_rdata),
    .conv_a(conv_a), .conv_b(conv_b), .conv_start(conv_start), .conv_clr(conv_clr),
    .conv_c(conv_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  // Integer-valued single-precision helpers (|v| < 2^24).
  function automatic logic [31:0] int2f(input int v);
    int p;
    logic [31:0] tmp;
    if (v <= 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    tmp = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), tmp[22:0]};
  endfunction

  function automatic int f2int(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  logic [31:0] pix_mem[256];
  logic [31:0] wgt_mem[256];
  always @(posedge clk) if (mem_rd) begin
    pix_rdata <= pix_mem[pix_addr[7:0]];
    wgt_rdata <= wgt_mem[wgt_addr[7:0]];
  end

  // BasicConv model: result visible MAC_LAT cycles after the start cycle.
  int acc_q = 0;
  logic [31:0] cdly[3];
  always @(posedge clk) begin
    if (conv_clr) acc_q <= 0;
    else if (conv_start) acc_q <= acc_q + f2int(conv_a) * f2int(conv_b);
    cdly[0] <= int2f(acc_q);
    cdly[1] <= cdly[0];
    cdly[2] <= cdly[1];
  end
  assign conv_c = cdly[2];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { int stall; int glitch; int pattern; int exp_done; } scen_t;

  wr_t exp_q[$];
  int  clr_log[$], start_log[$], done_log[$], pa_log[$], wa_log[$];
  int  cyc = 0, t0 = 0, b2b = 0, extra = 0;
  logic cs_prev = 1'b0, pv = 1'b0, pr = 1'b0;
  logic [ADDR_W-1:0] pa_prev = '0;
  logic [DATA_W-1:0] pd_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard at the falling edge.
  always @(negedge clk) begin
    int rel;
    wr_t e;
    if (rst_n) begin
      rel = cyc - t0;
      if (conv_clr) clr_log.push_back(rel);
      if (conv_start) start_log.push_back(rel);
      if (done) done_log.push_back(rel);
      if (mem_rd) begin
        pa_log.push_back(int'(pix_addr));
        wa_log.push_back(int'(wgt_addr));
      end
      if (conv_start && cs_prev) b2b++;
      if (out_valid && pv && !pr) begin
        chk("stall_out_addr", 64'(out_addr), 64'(pa_prev));
        chk("stall_out_data", 64'(out_data), 64'(pd_prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          $display("write: cycle %0d addr %0d data 0x%08h", rel, out_addr, out_data);
          chk("wr_addr", 64'(out_addr), 64'(e.addr));
          chk("wr_data", 64'(out_data), 64'(e.data));
          chk("wr_cycle", 64'(rel), 64'(e.cyc));
        end
      end
    end
    cs_prev = conv_start;
    pv = out_valid;
    pr = out_ready;
    pa_prev = out_addr;
    pd_prev = out_data;
  end

  task automatic load_mems(input int pattern);
    for (int p = 0; p < 256; p++) pix_mem[p] = '0;
    for (int p = 0; p < 256; p++) wgt_mem[p] = '0;
    for (int p = 0; p < IMG_W * IMG_H; p++) pix_mem[p] = pattern != 0 ? int2f(p + 1) : FLOAT_THREE;
    for (int k = 0; k < NTAP; k++) wgt_mem[k] = pattern != 0 ? int2f(k + 1) : FLOAT_ONE;
  endtask

  task automatic clear_logs();
    clr_log.delete(); start_log.delete(); done_log.delete();
    pa_log.delete(); wa_log.delete(); exp_q.delete();
    b2b = 0; extra = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 0);
    chk({tag, "_start"}, 64'(conv_start), 0);
    chk({tag, "_clr"}, 64'(conv_clr), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_pix_addr"}, 64'(pix_addr), 0);
    chk({tag, "_wgt_addr"}, 64'(wgt_addr), 0);
    chk({tag, "_out_addr"}, 64'(out_addr), 0);
    chk({tag, "_conv_a"}, 64'(conv_a), 0);
    chk({tag, "_conv_b"}, 64'(conv_b), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
  endtask

  task automatic run_pass(input scen_t s);
    int rel, sum, pv_i, wv_i;
    wr_t w;
    int pa_exp[9];
    pa_exp = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    load_mems(s.pattern);
    clear_logs();
    for (int wi = 0; wi < NWIN; wi++) begin
      sum = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          pv_i = s.pattern != 0 ? ((wi / OW) + i) * IMG_W + (wi % OW) + j + 1 : 3;
          wv_i = s.pattern != 0 ? i * K + j + 1 : 1;
          sum += pv_i * wv_i;
        end
      w.addr = wi;
      w.data = int2f(sum);
      w.cyc  = WIN_CYC * (wi + 1) + s.stall;
      exp_q.push_back(w);
    end
    @(posedge clk); #1;
    go = 1'b1; t0 = cyc; out_ready = 1'b1;
    for (int n = 1; n < 300; n++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      go = (rel == s.glitch);
      out_ready = !(rel >= WIN_CYC && rel < WIN_CYC + s.stall);
      if (rel == 1) chk("busy_after_go", 64'(busy), 1);
      if (rel == s.exp_done + 1) begin
        chk("busy_after_done", 64'(busy), 0);
        break;
      end
    end
    go = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("pass: stall %0d glitch %0d pattern %0d done_pulses %0d", s.stall, s.glitch, s.pattern, done_log.size());
    chk("done_pulses", 64'(done_log.size()), 1);
    if (done_log.size() > 0) chk("done_cycle", 64'(done_log[0]), 64'(s.exp_done));
    chk("writes_missing", 64'(exp_q.size()), 0);
    chk("writes_extra", 64'(extra), 0);
    chk("start_back_to_back", 64'(b2b), 0);
    chk("clr_count", 64'(clr_log.size()), NWIN);
    for (int k = 0; k < NWIN && k < clr_log.size(); k++)
      chk("clr_cycle", 64'(clr_log[k]), 64'(k == 0 ? 1 : WIN_CYC * k + 1 + s.stall));
    chk("start_count", 64'(start_log.size()), NWIN * NTAP);
    for (int t = 0; t < NTAP && t < start_log.size(); t++)
      chk("start_cycle", 64'(start_log[t]), 64'(4 + 2 * t));
    chk("fetch_count", 64'(pa_log.size()), NWIN * NTAP);
    if (pa_log.size() > 0) chk("first_pix_addr", 64'(pa_log[0]), 0);
    for (int t = 0; t < NTAP && NTAP + t < pa_log.size(); t++) begin
      chk("win01_pix_addr", 64'(pa_log[NTAP + t]), 64'(pa_exp[t]));
      chk("win01_wgt_addr", 64'(wa_log[NTAP + t]), 64'(t));
    end
    exp_q.delete();
  endtask

  scen_t scen[4];

  initial begin
    int rel;
    scen[0] = '{stall: 0, glitch: -1, pattern: 0, exp_done: 101};
    scen[1] = '{stall: 5, glitch: -1, pattern: 0, exp_done: 106};
    scen[2] = '{stall: 0, glitch: 10, pattern: 1, exp_done: 101};
    scen[3] = '{stall: 3, glitch: -1, pattern: 1, exp_done: 104};

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) run_pass(scen[k]);

    // Reset during DRAIN aborts the pass with no done pulse.
    load_mems(0);
    clear_logs();
    @(posedge clk); #1;
    go = 1'b1; t0 = cyc;
    for (int n = 1; n < 40; n++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      go = 1'b0;
      if (rel == 22) break;
    end
    chk("pre_reset_conv_a", 64'(conv_a), 64'(FLOAT_THREE));
    chk("pre_reset_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("aborted_done_pulses", 64'(done_log.size()), 0);
    chk("aborted_writes", 64'(extra), 0);
    run_pass(scen[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
